// File: rtl/latch_write_arbiter.sv
// Round-robin write sequencer for a shared bank of gated D latches.
// Each write runs setup -> enable (EN_CYCLES) -> hold, so Latch_D is stable
// for a full cycle on both sides of the level-sensitive Latch_Clk pulse.
module latch_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Data,
    output logic [N_REQ-1:0]       Grant,
    output logic                   Done,
    output logic                   Busy,
    output logic                   Latch_Clk,
    output logic [WIDTH-1:0]       Latch_D
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(EN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    state_t            state, next_state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     sel;
    logic              found;
    logic [CW-1:0]     cnt;
    logic              en_last;
    logic [WIDTH-1:0]  slice [N_REQ];

    // Unpack the flat data bus into one slice per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slice[g] = Data[g*WIDTH +: WIDTH];
    end

    assign en_last = (cnt == CW'(EN_CYCLES - 1));

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && Req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    // Next-state logic for the setup/enable/hold sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = SETUP;
            SETUP:   next_state = ENABLE;
            ENABLE:  if (en_last) next_state = HOLD;
            HOLD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register plus registered outputs, updated on each transition.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            Grant     <= '0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
            Latch_Clk <= 1'b0;
            Latch_D   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    // Latch_D is only loaded here, so it is frozen while granted.
                    if (found) begin
                        gidx    <= sel;
                        Grant   <= N_REQ'(1) << sel;
                        Latch_D <= slice[sel];
                        Busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    Latch_Clk <= 1'b1;
                    cnt       <= '0;
                end
                ENABLE: begin
                    if (en_last) begin
                        Latch_Clk <= 1'b0;
                        Done      <= 1'b1;
                        ptr       <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    Grant <= '0;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter: one instance with a single-cycle
// enable pulse and one with a three-cycle pulse, sharing all stimulus.
module tb_latch_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  Req;
    logic [31:0] Data;

    logic [3:0]  grant1, grant3;
    logic        done1, done3, busy1, busy3, lclk1, lclk3;
    logic [7:0]  ld1, ld3;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    latch_write_arbiter #(.N_REQ(4), .WIDTH(8), .EN_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Data(Data),
        .Grant(grant1), .Done(done1), .Busy(busy1),
        .Latch_Clk(lclk1), .Latch_D(ld1)
    );

    latch_write_arbiter #(.N_REQ(4), .WIDTH(8), .EN_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Data(Data),
        .Grant(grant3), .Done(done3), .Busy(busy3),
        .Latch_Clk(lclk3), .Latch_D(ld3)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req   = 4'b0000;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        logic [3:0] expg;
        logic [7:0] slc;
        int k, ph;

        Reset = 1'b1;
        Req   = 4'b1111;
        Data  = 32'h44332211;

        // Reset with all requests pending
        tick();
        chk("rst_grant", {28'd0, grant1}, 0);
        chk("rst_misc", {27'd0, done1, busy1, lclk1, 1'b0}, 0);
        chk("rst_ld", {24'd0, ld1}, 0);
        tick();
        chk("rst_grant2", {28'd0, grant1}, 0);
        Reset = 1'b0;
        tick();
        chk("rst_first_grant", {28'd0, grant1}, 32'h1);
        do_reset();

        // Single write from requester 1
        Data = 32'h0000A500;
        Req  = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("sw_grant_c%0d", c), {28'd0, grant1}, (c <= 3) ? 32'h2 : 32'h0);
            chk($sformatf("sw_lclk_c%0d", c), {31'd0, lclk1}, (c == 2) ? 32'h1 : 32'h0);
            chk($sformatf("sw_done_c%0d", c), {31'd0, done1}, (c == 3) ? 32'h1 : 32'h0);
            chk($sformatf("sw_busy_c%0d", c), {31'd0, busy1}, (c <= 3) ? 32'h1 : 32'h0);
            if (c <= 3) chk($sformatf("sw_ld_c%0d", c), {24'd0, ld1}, 32'hA5);
            if (c == 3) Req = 4'b0000;
        end
        do_reset();

        // All-request sweep, each requester drops after its own Done
        Data = 32'hD4C3B2A1;
        Req  = 4'b1111;
        for (int c = 1; c <= 16; c++) begin
            tick();
            k    = (c - 1) / 4;
            ph   = (c - 1) % 4;
            expg = (ph < 3) ? (4'b0001 << k) : 4'b0000;
            chk($sformatf("sweep_grant_c%0d", c), {28'd0, grant1}, {28'd0, expg});
            if (ph == 0) begin
                slc = (k == 0) ? 8'hA1 : (k == 1) ? 8'hB2 : (k == 2) ? 8'hC3 : 8'hD4;
                chk($sformatf("sweep_ld_c%0d", c), {24'd0, ld1}, {24'd0, slc});
            end
            if (ph == 2) begin
                chk($sformatf("sweep_done_c%0d", c), {31'd0, done1}, 32'h1);
                Req[k] = 1'b0;
            end
        end
        do_reset();

        // Persistent requests from 0 and 2 must alternate
        Req = 4'b0101;
        for (int c = 1; c <= 16; c++) begin
            tick();
            k    = (c - 1) / 4;
            ph   = (c - 1) % 4;
            expg = (ph == 3) ? 4'b0000 : ((k % 2 == 0) ? 4'b0001 : 4'b0100);
            chk($sformatf("fair_grant_c%0d", c), {28'd0, grant1}, {28'd0, expg});
            if (c == 16) Req = 4'b0000;
        end
        do_reset();

        // Data stability with a three-cycle enable pulse
        Data = 32'h0000003C;
        Req  = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("stab_lclk_c%0d", c), {31'd0, lclk3}, (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("stab_done_c%0d", c), {31'd0, done3}, (c == 5) ? 32'h1 : 32'h0);
            if (c <= 5) chk($sformatf("stab_ld_c%0d", c), {24'd0, ld3}, 32'h3C);
            if (c == 3) Data = 32'h000000C3;
            if (c == 5) Req = 4'b0000;
        end
        chk("stab_grant_idle", {28'd0, grant3}, 0);
        do_reset();

        // Move the pointer to 3 with a write from requester 2
        Req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3) Req = 4'b0000;
        end
        // Reset in the enable cycle of a write from requester 3
        Req = 4'b1000;
        tick();
        chk("rmid_grant_c1", {28'd0, grant1}, 32'h8);
        tick();
        chk("rmid_lclk_c2", {31'd0, lclk1}, 32'h1);
        Reset = 1'b1;
        Req   = 4'b0000;
        tick();
        chk("rmid_lclk_after", {31'd0, lclk1}, 0);
        chk("rmid_grant_after", {28'd0, grant1}, 0);
        chk("rmid_busy_after", {31'd0, busy1}, 0);
        chk("rmid_done_after", {31'd0, done1}, 0);
        Reset = 1'b0;
        tick();
        tick();
        chk("rmid_no_done", {30'd0, done1, busy1}, 0);
        // Pointer is back at 0, so requester 0 wins over 3
        Req = 4'b1001;
        tick();
        chk("rmid_ptr0_grant", {28'd0, grant1}, 32'h1);
        tick();
        tick();
        chk("rmid_ptr0_done", {31'd0, done1}, 32'h1);
        Req = 4'b1000;
        tick();
        tick();
        chk("rmid_req3_grant", {28'd0, grant1}, 32'h8);
        chk("rmid_req3_busy", {31'd0, busy1}, 32'h1);
        Req = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
